// File: rtl/circular_request_tracker_pkg.sv
// Shared types and width helpers for the circular request tracker.
// Optional performance counters are enabled with REQ_TRACKER_PERF_COUNTER_EN.
package circular_request_tracker_pkg;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_WAIT,
    ST_REQ,
    ST_DONE
  } entry_state_e;

  // Slot index width.
  function automatic int idx_w(input int entry_num);
    return $clog2(entry_num);
  endfunction

  // Head/tail pointer width, including the wrap bit that separates full from empty.
  function automatic int ptr_w(input int entry_num);
    return $clog2(entry_num) + 1;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/circular_request_tracker_retire_scan.sv
// Counts leading DONE entries starting at head, wrapping around the ring,
// capped by RETIRE_NUM and by the number of valid entries.
module circular_request_tracker_retire_scan
  import circular_request_tracker_pkg::*;
#(
  parameter  int ENTRY_NUM  = 16,
  parameter  int RETIRE_NUM = 2,
  localparam int IDX        = idx_w(ENTRY_NUM),
  localparam int CW         = ptr_w(ENTRY_NUM),
  localparam int KW         = $clog2(RETIRE_NUM + 1)
) (
  input  entry_state_e   state [ENTRY_NUM],
  input  logic [IDX-1:0] head,
  input  logic [CW-1:0]  count,
  output logic [KW-1:0]  k
);

  logic           run;
  logic [IDX-1:0] slot;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    k    = '0;
    run  = 1'b1;
    slot = head;
    for (int i = 0; i < RETIRE_NUM; i++) begin
      slot = head + IDX'(i);
      if (run && (CW'(i) < count) && (state[slot] == ST_DONE)) begin
        k = k + KW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/circular_request_tracker.sv
// Circular queue of request slots feeding a picker: in-order alloc at tail, in-order retire at head.
// Define REQ_TRACKER_PERF_COUNTER_EN to add saturating grant and full-cycle counters.
module circular_request_tracker
  import circular_request_tracker_pkg::*;
#(
  parameter  int ENTRY_NUM  = 16,
  parameter  int ALLOC_NUM  = 2,
  parameter  int RETIRE_NUM = 2,
  localparam int IDX        = idx_w(ENTRY_NUM),
  localparam int CW         = ptr_w(ENTRY_NUM),
  localparam int AW         = $clog2(ALLOC_NUM + 1),
  localparam int KW         = $clog2(RETIRE_NUM + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [AW-1:0]                 allocNum,
  output logic                          allocReady,
  output logic [ALLOC_NUM-1:0][IDX-1:0] allocPtr,
  input  logic [ENTRY_NUM-1:0]          setReady,
  input  logic [ENTRY_NUM-1:0]          grant,
  output logic [ENTRY_NUM-1:0]          req,
  output logic [IDX-1:0]                headPtr,
  output logic [IDX-1:0]                tailPtr,
  output logic [CW-1:0]                 count,
  output logic                          full,
  output logic                          empty,
`ifdef REQ_TRACKER_PERF_COUNTER_EN
  output logic [31:0]                   perfGrantCnt,
  output logic [31:0]                   perfFullCycles,
`endif
  output logic [KW-1:0]                 retired
);

  entry_state_e         state_q [ENTRY_NUM];
  logic [CW-1:0]        head_q;
  logic [CW-1:0]        tail_q;
  logic [KW-1:0]        retired_q;
  logic [KW-1:0]        k;
  logic [AW-1:0]        alloc_n;
  logic [ENTRY_NUM-1:0] alloc_mask;
  logic [ENTRY_NUM-1:0] retire_mask;

  assign count      = tail_q - head_q;
  assign full       = (count == CW'(ENTRY_NUM));
  assign empty      = (count == '0);
  assign allocReady = ((CW'(ENTRY_NUM) - count) >= CW'(ALLOC_NUM));
  assign headPtr    = head_q[IDX-1:0];
  assign tailPtr    = tail_q[IDX-1:0];
  assign retired    = retired_q;

  // Requests beyond ALLOC_NUM or while not ready are dropped whole.
  assign alloc_n = (allocReady && (allocNum <= AW'(ALLOC_NUM))) ? allocNum : '0;

  circular_request_tracker_retire_scan #(
    .ENTRY_NUM (ENTRY_NUM),
    .RETIRE_NUM(RETIRE_NUM)
  ) u_retire_scan (
    .state(state_q),
    .head (head_q[IDX-1:0]),
    .count(count),
    .k    (k)
  );

  always_comb begin
    req         = '0;
    alloc_mask  = '0;
    retire_mask = '0;
    for (int e = 0; e < ENTRY_NUM; e++) begin
      req[e] = (state_q[e] == ST_REQ);
    end
    for (int i = 0; i < ALLOC_NUM; i++) begin
      allocPtr[i] = tail_q[IDX-1:0] + IDX'(i);
      if (AW'(i) < alloc_n) alloc_mask[tail_q[IDX-1:0] + IDX'(i)] = 1'b1;
    end
    for (int i = 0; i < RETIRE_NUM; i++) begin
      if (KW'(i) < k) retire_mask[head_q[IDX-1:0] + IDX'(i)] = 1'b1;
    end
  end

  // NOTE: the state array is control, not storage, so every entry is reset to FREE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < ENTRY_NUM; e++) state_q[e] <= ST_FREE;
      head_q    <= '0;
      tail_q    <= '0;
      retired_q <= '0;
    end else if (flush) begin
      for (int e = 0; e < ENTRY_NUM; e++) state_q[e] <= ST_FREE;
      head_q    <= '0;
      tail_q    <= '0;
      retired_q <= '0;
    end else begin
      // Each transition is keyed on the state at the edge, so the cases never overlap.
      for (int e = 0; e < ENTRY_NUM; e++) begin
        case (state_q[e])
          ST_FREE: if (alloc_mask[e])  state_q[e] <= ST_WAIT;
          ST_WAIT: if (setReady[e])    state_q[e] <= ST_REQ;
          ST_REQ:  if (grant[e])       state_q[e] <= ST_DONE;
          ST_DONE: if (retire_mask[e]) state_q[e] <= ST_FREE;
        endcase
      end
      head_q    <= head_q + CW'(k);
      tail_q    <= tail_q + CW'(alloc_n);
      retired_q <= k;
    end
  end

`ifdef REQ_TRACKER_PERF_COUNTER_EN
  logic [31:0] grant_pop;

  assign grant_pop = 32'($countones(req & grant));

  // Cleared only by rst; flush discards that cycle's grants but keeps history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfGrantCnt   <= '0;
      perfFullCycles <= '0;
    end else begin
      if (!flush) perfGrantCnt <= sat_add32(perfGrantCnt, grant_pop);
      if (full)   perfFullCycles <= sat_add32(perfFullCycles, 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_circular_request_tracker.sv
// Self-checking bench for circular_request_tracker (ENTRY_NUM=8) against a slot-level model.
// Also checks the perf counters when REQ_TRACKER_PERF_COUNTER_EN is defined.
module tb_circular_request_tracker;

  localparam int N = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [1:0]       allocNum = '0;
  logic             allocReady;
  logic [1:0][2:0]  allocPtr;
  logic [N-1:0]     setReady = '0;
  logic [N-1:0]     grant = '0;
  logic [N-1:0]     req;
  logic [2:0]       headPtr;
  logic [2:0]       tailPtr;
  logic [3:0]       count;
  logic             full;
  logic             empty;
  logic [1:0]       retired;
`ifdef REQ_TRACKER_PERF_COUNTER_EN
  logic [31:0]      perfGrantCnt;
  logic [31:0]      perfFullCycles;
`endif

  circular_request_tracker #(
    .ENTRY_NUM (N),
    .ALLOC_NUM (2),
    .RETIRE_NUM(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .allocNum  (allocNum),
    .allocReady(allocReady),
    .allocPtr  (allocPtr),
    .setReady  (setReady),
    .grant     (grant),
    .req       (req),
    .headPtr   (headPtr),
    .tailPtr   (tailPtr),
    .count     (count),
    .full      (full),
    .empty     (empty),
`ifdef REQ_TRACKER_PERF_COUNTER_EN
    .perfGrantCnt  (perfGrantCnt),
    .perfFullCycles(perfFullCycles),
`endif
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Model: per-slot lifecycle 0=free 1=waiting 2=requesting 3=done; head/tail as plain counters.
  int m_st [N];
  int m_head, m_tail, m_cnt, m_ret;
  int m_pgrant, m_pfull;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset(input bit keep_perf);
    for (int e = 0; e < N; e++) m_st[e] = 0;
    m_head = 0; m_tail = 0; m_cnt = 0; m_ret = 0;
    if (!keep_perf) begin
      m_pgrant = 0; m_pfull = 0;
    end
  endtask

  task automatic model_edge(input int an, input logic [N-1:0] sr, input logic [N-1:0] g, input logic fl);
    int k;
    int n_alloc;
    k = 0;
    for (int i = 0; i < 2; i++)
      if (k == i && i < m_cnt && m_st[(m_head + i) % N] == 3) k++;
    n_alloc = ((N - m_cnt) >= 2) ? an : 0;
    if (m_cnt == N) m_pfull++;
    if (!fl)
      for (int e = 0; e < N; e++) if (m_st[e] == 2 && g[e]) m_pgrant++;
    if (fl) begin
      model_reset(1'b1);
    end else begin
      for (int e = 0; e < N; e++) begin
        if (m_st[e] == 1 && sr[e]) m_st[e] = 2;
        else if (m_st[e] == 2 && g[e]) m_st[e] = 3;
      end
      for (int i = 0; i < k; i++) m_st[(m_head + i) % N] = 0;
      for (int i = 0; i < n_alloc; i++) m_st[(m_tail + i) % N] = 1;
      m_head += k;
      m_tail += n_alloc;
      m_cnt  += n_alloc - k;
      m_ret   = k;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_req;
    for (int e = 0; e < N; e++) exp_req[e] = (m_st[e] == 2);
    check("req", 32'(req), 32'(exp_req));
    check("head", 32'(headPtr), 32'(m_head % N));
    check("tail", 32'(tailPtr), 32'(m_tail % N));
    check("count", 32'(count), 32'(m_cnt));
    check("full", 32'(full), 32'(m_cnt == N));
    check("empty", 32'(empty), 32'(m_cnt == 0));
    check("alloc_ready", 32'(allocReady), 32'((N - m_cnt) >= 2));
    check("retired", 32'(retired), 32'(m_ret));
`ifdef REQ_TRACKER_PERF_COUNTER_EN
    check("perf_grant", perfGrantCnt, 32'(m_pgrant));
    check("perf_full", perfFullCycles, 32'(m_pfull));
`endif
  endtask

  // One clock cycle: drive inputs, check combinational allocPtr, step the model at the edge.
  task automatic apply(input int an, input logic [N-1:0] sr, input logic [N-1:0] g, input logic fl);
    allocNum = 2'(an);
    setReady = sr;
    grant    = g;
    flush    = fl;
    #1;
    check("alloc_ptr0", 32'(allocPtr[0]), 32'(m_tail % N));
    check("alloc_ptr1", 32'(allocPtr[1]), 32'((m_tail + 1) % N));
    @(posedge clk);
    model_edge(an, sr, g, fl);
    #1;
    allocNum = '0; setReady = '0; grant = '0; flush = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset(1'b0);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic alloc / request / grant / retire.
    apply(2, 8'h00, 8'h00, 0);
    apply(0, 8'h03, 8'h00, 0);
    check("t1_req_set", 32'(req), 32'h03);
    apply(0, 8'h00, 8'h01, 0);
    check("t1_req_grant", 32'(req), 32'h02);
    apply(0, 8'h00, 8'h00, 0);
    check("t1_retired", 32'(retired), 32'd1);
    check("t1_head", 32'(headPtr), 32'd1);
    apply(0, 8'h00, 8'h02, 0);
    apply(0, 8'h00, 8'h00, 0);

    // Out-of-order grant: younger slot waits for the head.
    apply(2, 8'h00, 8'h00, 0);
    apply(0, 8'h0C, 8'h00, 0);
    apply(0, 8'h00, 8'h08, 0);
    apply(0, 8'h00, 8'h00, 0);
    check("t2_no_retire", 32'(retired), 32'd0);
    check("t2_head_hold", 32'(headPtr), 32'd2);
    apply(0, 8'h00, 8'h04, 0);
    apply(0, 8'h00, 8'h00, 0);
    check("t2_retired2", 32'(retired), 32'd2);
    check("t2_head", 32'(headPtr), 32'd4);

    // Fill, blocked alloc, drain.
    for (int i = 0; i < 4; i++) apply(2, 8'h00, 8'h00, 0);
    check("t3_full", 32'(full), 32'd1);
    check("t3_not_ready", 32'(allocReady), 32'd0);
    apply(2, 8'h00, 8'h00, 0);
    check("t3_tail_hold", 32'(tailPtr), 32'd4);
    apply(0, 8'hFF, 8'h00, 0);
    apply(0, 8'h00, 8'hFF, 0);
    apply(0, 8'h00, 8'h00, 0);
    check("t3_count6", 32'(count), 32'd6);
    check("t3_ready", 32'(allocReady), 32'd1);
    for (int i = 0; i < 3; i++) apply(0, 8'h00, 8'h00, 0);

    // Wrap: alloc across 7 -> 0, retire across it.
    apply(2, 8'h00, 8'h00, 0);
    apply(1, 8'h00, 8'h00, 0);
    apply(0, 8'h70, 8'h00, 0);
    apply(0, 8'h00, 8'h70, 0);
    apply(0, 8'h00, 8'h00, 0);
    apply(0, 8'h00, 8'h00, 0);
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_aptr0", 32'(allocPtr[0]), 32'd7);
    check("t4_aptr1", 32'(allocPtr[1]), 32'd0);
    apply(2, 8'h00, 8'h00, 0);
    check("t4_tail", 32'(tailPtr), 32'd1);
    check("t4_count", 32'(count), 32'd2);
    apply(0, 8'h81, 8'h00, 0);
    apply(0, 8'h00, 8'h81, 0);
    apply(0, 8'h00, 8'h00, 0);
    check("t4_head", 32'(headPtr), 32'd1);

    // Flush mid-stream, then asynchronous reset between edges.
    apply(2, 8'h00, 8'h00, 0);
    apply(2, 8'h00, 8'h00, 0);
    apply(1, 8'h00, 8'h00, 0);
    apply(0, 8'h16, 8'h00, 0);
    check("t5_req", 32'(req), 32'h16);
    apply(2, 8'hFF, 8'hFF, 1);
    check("t5_flush_empty", 32'(empty), 32'd1);
    check("t5_flush_req", 32'(req), 32'h00);
    check("t5_flush_tail", 32'(tailPtr), 32'd0);
    apply(2, 8'h00, 8'h00, 0);
    apply(2, 8'h03, 8'h00, 0);
    #2;
    rst = 1'b1;
    model_reset(1'b0);
    #1;
    check_all();
    check("t5_rst_count", 32'(count), 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic; alloc only requested when the model says it is accepted.
    for (int c = 0; c < 400; c++) begin
      int an;
      logic fl;
      an = ((N - m_cnt) >= 2) ? int'($urandom_range(0, 2)) : 0;
      fl = ($urandom_range(0, 39) == 0);
      apply(an, N'($urandom), N'($urandom & $urandom), fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
